// File: rtl/axi_req_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi_req_arbiter
//   Bridges a CPU-side inst/data request interface onto a single AXI3 master
//   port. Reads are serialised (one outstanding read of either source). Writes
//   run on their own FSM and may overlap an inst read, but never a data read,
//   so a data read always sees the result of an earlier data write.
//
// Ports
//   aclk, areset             clock and synchronous active-high reset
//   inst_req/addr            inst read request; inst_addr_ok accepts it
//   inst_data_ok/rdata       inst read completion pulse and held read data
//   data_req/wr/size/addr/   data read or write request; data_addr_ok
//   wstrb/wdata                accepts it
//   data_data_ok/rdata       data completion pulse and held read data
//   ar*/r*                   AXI3 read address / read data channels
//   aw*/w*/b*                AXI3 write address / write data / response
// -----------------------------------------------------------------------------
module axi_req_arbiter (
   input  logic        aclk,
   input  logic        areset,
   // inst read port
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // AXI3 read address
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI3 read data
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   // AXI3 write address
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // AXI3 write data
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // AXI3 write response
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

   r_state_e    r_state_q, r_state_d;
   w_state_e    w_state_q, w_state_d;
   logic        r_is_data_q, r_is_data_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [2:0]  r_size_q, r_size_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        inst_ok_q, inst_ok_d;
   logic        data_rd_ok_q, data_rd_ok_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [2:0]  w_size_q, w_size_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic [31:0] w_data_q, w_data_d;
   logic        aw_pend_q, aw_pend_d;
   logic        w_pend_q, w_pend_d;

   logic        data_rd_acc, inst_rd_acc, data_wr_acc;

   // Single outstanding transaction per channel and no error reporting, so
   // IDs, responses and rlast carry no information here.
   logic unused_inputs;
   assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

   // Request acceptance. A data read needs both FSMs idle (read-after-write
   // ordering); a data write must not overlap an in-flight data read.
   always_comb begin
      data_rd_acc = !areset && (r_state_q == R_IDLE) && (w_state_q == W_IDLE)
                    && data_req && !data_wr;
      inst_rd_acc = !areset && (r_state_q == R_IDLE) && inst_req && !data_rd_acc;
      data_wr_acc = !areset && (w_state_q == W_IDLE) && data_req && data_wr
                    && !data_rd_acc && !((r_state_q != R_IDLE) && r_is_data_q);
   end

   // State register
   always_ff @(posedge aclk) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      if (areset) begin
         r_state_q    <= R_IDLE;
         w_state_q    <= W_IDLE;
         r_is_data_q  <= 1'b0;
         r_addr_q     <= '0;
         r_size_q     <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_ok_q    <= 1'b0;
         data_rd_ok_q <= 1'b0;
         w_addr_q     <= '0;
         w_size_q     <= '0;
         w_strb_q     <= '0;
         w_data_q     <= '0;
         aw_pend_q    <= 1'b0;
         w_pend_q     <= 1'b0;
      end else begin
         r_state_q    <= r_state_d;
         w_state_q    <= w_state_d;
         r_is_data_q  <= r_is_data_d;
         r_addr_q     <= r_addr_d;
         r_size_q     <= r_size_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_ok_q    <= inst_ok_d;
         data_rd_ok_q <= data_rd_ok_d;
         w_addr_q     <= w_addr_d;
         w_size_q     <= w_size_d;
         w_strb_q     <= w_strb_d;
         w_data_q     <= w_data_d;
         aw_pend_q    <= aw_pend_d;
         w_pend_q     <= w_pend_d;
      end
   end

   // Next-state logic for both FSMs
   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path through
      // the case statements can leave it unassigned (which would infer a latch).
      r_state_d    = r_state_q;
      r_is_data_d  = r_is_data_q;
      r_addr_d     = r_addr_q;
      r_size_d     = r_size_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_ok_d    = 1'b0;
      data_rd_ok_d = 1'b0;
      w_state_d    = w_state_q;
      w_addr_d     = w_addr_q;
      w_size_d     = w_size_q;
      w_strb_d     = w_strb_q;
      w_data_d     = w_data_q;
      aw_pend_d    = aw_pend_q;
      w_pend_d     = w_pend_q;

      unique case (r_state_q)
         R_IDLE: begin
            if (data_rd_acc) begin
               r_state_d   = R_ADDR;
               r_is_data_d = 1'b1;
               r_addr_d    = data_addr;
               r_size_d    = {1'b0, data_size};
            end else if (inst_rd_acc) begin
               r_state_d   = R_ADDR;
               r_is_data_d = 1'b0;
               r_addr_d    = inst_addr;
               r_size_d    = 3'b010;
            end
         end
         R_ADDR: if (arready) r_state_d = R_DATA;
         R_DATA: begin
            if (rvalid) begin
               r_state_d = R_IDLE;
               if (r_is_data_q) begin
                  data_rdata_d = rdata;
                  data_rd_ok_d = 1'b1;
               end else begin
                  inst_rdata_d = rdata;
                  inst_ok_d    = 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase

      unique case (w_state_q)
         W_IDLE: begin
            if (data_wr_acc) begin
               w_state_d = W_SEND;
               w_addr_d  = data_addr;
               w_size_d  = {1'b0, data_size};
               w_strb_d  = data_wstrb;
               w_data_d  = data_wdata;
               aw_pend_d = 1'b1;
               w_pend_d  = 1'b1;
            end
         end
         W_SEND: begin
            // AW and W complete independently; leave once both are done,
            // including when both handshake in the same cycle.
            aw_pend_d = aw_pend_q && !awready;
            w_pend_d  = w_pend_q && !wready;
            if (!aw_pend_d && !w_pend_d) w_state_d = W_RESP;
         end
         W_RESP: if (bvalid) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      inst_addr_ok = inst_rd_acc;
      data_addr_ok = data_rd_acc || data_wr_acc;
      inst_data_ok = inst_ok_q;
      // Write completion is reported in the b-handshake cycle itself.
      data_data_ok = data_rd_ok_q || (!areset && (w_state_q == W_RESP) && bvalid);
      inst_rdata   = inst_rdata_q;
      data_rdata   = data_rdata_q;
      arvalid      = (r_state_q == R_ADDR);
      rready       = (r_state_q == R_DATA);
      awvalid      = (w_state_q == W_SEND) && aw_pend_q;
      wvalid       = (w_state_q == W_SEND) && w_pend_q;
      bready       = (w_state_q == W_RESP);
   end

   assign arid    = r_is_data_q ? 4'd1 : 4'd0;
   assign araddr  = r_addr_q;
   assign arsize  = r_size_q;
   assign arlen   = 4'd0;
   assign arburst = 2'b01;
   assign arlock  = 2'd0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = 4'b0001;
   assign awaddr  = w_addr_q;
   assign awsize  = w_size_q;
   assign awlen   = 4'd0;
   assign awburst = 2'b01;
   assign awlock  = 2'd0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wid     = 4'b0001;
   assign wdata   = w_data_q;
   assign wstrb   = w_strb_q;
   assign wlast   = 1'b1;

endmodule

// File: tb/tb_axi_req_arbiter.sv
`timescale 1ns/1ps
module tb_axi_req_arbiter;

   logic        aclk, areset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid, arlen, arcache;
   logic [31:0] araddr;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid, awlen, awcache;
   logic [31:0] awaddr;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock;
   logic        awvalid, awready;
   logic [3:0]  wid, wstrb;
   logic [31:0] wdata;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   axi_req_arbiter dut (
      .aclk(aclk), .areset(areset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_exp_t;
   typedef struct { logic [31:0] addr; logic [2:0] size; } aw_exp_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
   typedef struct { bit is_rd; logic [31:0] rdata; } done_exp_t;

   // Scoreboard queues, filled when a request is accepted
   ar_exp_t     ar_q[$];
   aw_exp_t     aw_q[$];
   w_exp_t      w_q[$];
   logic [31:0] inst_q[$];
   done_exp_t   data_q[$];
   int          rd_out, drd_out, wr_out;
   logic [31:0] last_inst, last_data;

   int  checks = 0;
   int  errors = 0;
   bit  stall  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave memory contents: a fixed hash of the address, boot word special-cased.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h3C1D_0000;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: acceptance rules and expected responses
   task automatic monitor();
      bit w_idle, r_idle, d_busy, exp_inst, exp_drd, exp_dwr;
      logic [31:0] e_inst;
      done_exp_t e_done;
      ar_exp_t e_ar;
      aw_exp_t e_aw;
      w_exp_t e_w;
      forever begin
         @(negedge aclk);
         if (areset) begin
            check("addr_ok_during_reset", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            ar_q.delete(); aw_q.delete(); w_q.delete(); inst_q.delete(); data_q.delete();
            rd_out = 0; drd_out = 0; wr_out = 0; last_inst = '0; last_data = '0;
            continue;
         end
         // Writes return to idle the cycle after their completion pulse.
         w_idle = (wr_out == 0);
         if (inst_data_ok) begin
            check("inst_data_ok_has_pending", 32'(inst_q.size() != 0), 32'd1);
            if (inst_q.size() != 0) begin
               e_inst = inst_q.pop_front();
               check("inst_rdata", inst_rdata, e_inst);
               last_inst = e_inst;
               rd_out--;
            end
         end else check("inst_rdata_hold", inst_rdata, last_inst);
         if (data_data_ok) begin
            check("data_data_ok_has_pending", 32'(data_q.size() != 0), 32'd1);
            if (data_q.size() != 0) begin
               e_done = data_q.pop_front();
               if (e_done.is_rd) begin
                  check("data_rdata", data_rdata, e_done.rdata);
                  last_data = e_done.rdata;
                  rd_out--;
                  drd_out--;
               end else wr_out--;
            end
         end else check("data_rdata_hold", data_rdata, last_data);
         // Reads are idle in the cycle their completion pulse shows.
         r_idle   = (rd_out == 0);
         d_busy   = (drd_out != 0);
         exp_drd  = data_req && !data_wr && r_idle && w_idle;
         exp_inst = inst_req && r_idle && !exp_drd;
         exp_dwr  = data_req && data_wr && w_idle && !d_busy;
         check("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_inst));
         check("data_addr_ok", 32'(data_addr_ok), 32'(exp_drd || exp_dwr));
         if (exp_inst) begin
            ar_q.push_back('{id: 4'd0, addr: inst_addr, size: 3'b010});
            inst_q.push_back(mem_word(inst_addr));
            rd_out++;
         end
         if (exp_drd) begin
            ar_q.push_back('{id: 4'd1, addr: data_addr, size: {1'b0, data_size}});
            data_q.push_back('{is_rd: 1'b1, rdata: mem_word(data_addr)});
            rd_out++;
            drd_out++;
         end
         if (exp_dwr) begin
            aw_q.push_back('{addr: data_addr, size: {1'b0, data_size}});
            w_q.push_back('{data: data_wdata, strb: data_wstrb});
            data_q.push_back('{is_rd: 1'b0, rdata: 32'd0});
            wr_out++;
         end
         if (arvalid && arready) begin
            check("ar_has_pending", 32'(ar_q.size() != 0), 32'd1);
            if (ar_q.size() != 0) begin
               e_ar = ar_q.pop_front();
               check("arid", 32'(arid), 32'(e_ar.id));
               check("araddr", araddr, e_ar.addr);
               check("arsize", 32'(arsize), 32'(e_ar.size));
               check("ar_fixed_fields", 32'({arlen, arburst, arlock, arcache, arprot}),
                     32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
            end
         end
         if (awvalid && awready) begin
            check("aw_has_pending", 32'(aw_q.size() != 0), 32'd1);
            if (aw_q.size() != 0) begin
               e_aw = aw_q.pop_front();
               check("awaddr", awaddr, e_aw.addr);
               check("awsize", 32'(awsize), 32'(e_aw.size));
               check("aw_fixed_fields", 32'({awid, awlen, awburst, awlock, awcache, awprot}),
                     32'({4'b0001, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
            end
         end
         if (wvalid && wready) begin
            check("w_has_pending", 32'(w_q.size() != 0), 32'd1);
            if (w_q.size() != 0) begin
               e_w = w_q.pop_front();
               check("wdata", wdata, e_w.data);
               check("wstrb", 32'(wstrb), 32'(e_w.strb));
               check("w_fixed_fields", 32'({wid, wlast}), 32'({4'b0001, 1'b1}));
            end
         end
      end
   endtask

   // AXI slave with random ready/valid timing; stall freezes it mid-transfer.
   task automatic slave();
      logic [35:0] s_rq[$];
      logic [35:0] e;
      int r_dly = 0, b_dly = 0;
      bit aw_seen = 0, w_seen = 0;
      bit rst, ar_hs, r_hs, aw_hs, w_hs, b_hs;
      logic [3:0] a_id;
      logic [31:0] a_addr;
      forever begin
         @(negedge aclk);
         rst = areset; ar_hs = arvalid && arready; a_id = arid; a_addr = araddr;
         r_hs = rvalid && rready; aw_hs = awvalid && awready; w_hs = wvalid && wready;
         b_hs = bvalid && bready;
         @(posedge aclk); #1;
         if (rst) begin
            s_rq.delete(); aw_seen = 0; w_seen = 0;
            rvalid = 0; bvalid = 0; arready = 0; awready = 0; wready = 0;
            continue;
         end
         if (r_hs) rvalid = 1'b0;
         if (b_hs) bvalid = 1'b0;
         if (ar_hs) begin
            s_rq.push_back({a_id, a_addr});
            r_dly = $urandom_range(0, 3);
         end
         if (aw_hs) aw_seen = 1;
         if (w_hs) w_seen = 1;
         if (!stall && !rvalid && s_rq.size() != 0) begin
            if (r_dly == 0) begin
               e = s_rq.pop_front();
               rvalid = 1'b1; rid = e[35:32]; rdata = mem_word(e[31:0]);
               rresp = 2'($urandom_range(0, 3));
            end else r_dly--;
         end
         if (!stall && !bvalid && aw_seen && w_seen) begin
            if (b_dly == 0) begin
               bvalid = 1'b1; aw_seen = 0; w_seen = 0;
               bresp = 2'($urandom_range(0, 3));
               b_dly = $urandom_range(0, 3);
            end else b_dly--;
         end
         arready = stall ? 1'b1 : 1'($urandom_range(0, 1));
         awready = stall ? 1'b0 : 1'($urandom_range(0, 1));
         wready  = stall ? 1'b0 : 1'($urandom_range(0, 1));
      end
   endtask

   // Request drivers: entered and left at posedge+1, so calls chain back-to-back.
   task automatic idle(input int n);
      repeat (n) begin @(posedge aclk); #1; end
   endtask

   task automatic inst_read(input logic [31:0] a);
      int n = 0;
      inst_req = 1'b1; inst_addr = a;
      forever begin
         @(negedge aclk);
         if (inst_addr_ok) break;
         n++;
         if (n > 1000) begin
            check("inst_addr_ok_timeout", 32'(inst_addr_ok), 32'd1);
            break;
         end
      end
      @(posedge aclk); #1;
      inst_req = 1'b0;
   endtask

   task automatic data_access(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                              input logic [3:0] st, input logic [31:0] d);
      int n = 0;
      data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a;
      data_wstrb = st; data_wdata = d;
      forever begin
         @(negedge aclk);
         if (data_addr_ok) break;
         n++;
         if (n > 1000) begin
            check("data_addr_ok_timeout", 32'(data_addr_ok), 32'd1);
            break;
         end
      end
      @(posedge aclk); #1;
      data_req = 1'b0;
   endtask

   task automatic inst_random();
      logic [31:0] a;
      a = $urandom();
      a[1:0] = 2'b00;
      inst_read(a);
   endtask

   task automatic data_random();
      logic [31:0] a, d;
      logic [1:0] sz;
      a = $urandom(); d = $urandom();
      sz = 2'($urandom_range(0, 2));
      if (sz == 2'd2) a[1:0] = 2'b00;
      else if (sz == 2'd1) a[0] = 1'b0;
      data_access(1'($urandom_range(0, 1)), sz, a, 4'($urandom_range(0, 15)), d);
   endtask

   task automatic random_phase(input int n);
      fork
         for (int i = 0; i < n; i++) begin inst_random(); idle($urandom_range(0, 3)); end
         for (int i = 0; i < n; i++) begin data_random(); idle($urandom_range(0, 3)); end
      join
   endtask

   task automatic wait_quiet();
      int n = 0;
      forever begin
         @(negedge aclk);
         if (ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 &&
             inst_q.size() == 0 && data_q.size() == 0) break;
         n++;
         if (n > 3000) begin
            check("drain_timeout_pending_reads", 32'(inst_q.size() + data_q.size()), 32'd0);
            break;
         end
      end
      @(posedge aclk); #1;
   endtask

   initial begin
      areset = 1'b1;
      inst_req = 0; inst_addr = '0;
      data_req = 0; data_wr = 0; data_size = '0; data_addr = '0; data_wstrb = '0; data_wdata = '0;
      arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 0;
      awready = 0; wready = 0; bid = 4'b0001; bresp = '0; bvalid = 0;
      fork
         monitor();
         slave();
         begin
            #500000;
            $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
            $fatal(1, "watchdog expired");
         end
      join_none

      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(negedge aclk);
      check("reset_valids_readys", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
      check("reset_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      check("reset_inst_rdata", inst_rdata, 32'd0);
      check("reset_data_rdata", data_rdata, 32'd0);
      @(posedge aclk); #1;

      // Boot fetch
      inst_read(32'hBFC0_0000);
      wait_quiet();
      check("boot_inst_rdata", inst_rdata, 32'h3C1D_0000);

      // Simultaneous inst and data read: data goes first
      fork
         inst_read(32'hBFC0_0004);
         data_access(1'b0, 2'd2, 32'h8000_1000, 4'hF, 32'd0);
      join
      wait_quiet();

      // Write, then a data read that must wait for it, with an inst read alongside
      fork
         begin
            data_access(1'b1, 2'd2, 32'h8000_0010, 4'b0011, 32'hDEAD_BEEF);
            data_access(1'b0, 2'd2, 32'h8000_0010, 4'hF, 32'd0);
         end
         begin idle(1); inst_read(32'h8000_0200); end
      join
      wait_quiet();

      // Byte reads at an unaligned address, back to back
      data_access(1'b0, 2'd0, 32'h8000_0003, 4'hF, 32'd0);
      data_access(1'b0, 2'd0, 32'h8000_0003, 4'hF, 32'd0);
      wait_quiet();

      random_phase(80);
      wait_quiet();

      // Reset with a read in R_DATA and a write stuck in W_SEND
      stall = 1'b1;
      idle(1);
      inst_req = 1'b1; inst_addr = 32'h8000_2000;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_3000;
      data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
      @(negedge aclk);
      check("rst_setup_accepts", 32'({inst_addr_ok, data_addr_ok}), 32'b11);
      @(posedge aclk); #1;
      inst_req = 1'b0; data_req = 1'b0;
      idle(3);
      @(negedge aclk);
      check("rst_setup_inflight", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'b01110);
      @(posedge aclk); #1 areset = 1'b1;
      @(posedge aclk); #1 areset = 1'b0;
      @(negedge aclk);
      check("post_reset_valids_readys", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
      check("post_reset_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      stall = 1'b0;
      @(posedge aclk); #1;
      idle(4);
      inst_read(32'hBFC0_0000);
      wait_quiet();
      check("post_reset_inst_rdata", inst_rdata, 32'h3C1D_0000);

      random_phase(40);
      wait_quiet();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_req_arbiter.md
AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have port: aclk  in  1  sole clock; all logic is on the rising edge.
REQ-003 SHALL have port: areset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have inst read ports: inst_req in 1, inst_addr in 32, inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out 32.
REQ-005 SHALL have data ports: data_req in 1, data_wr in 1, data_size in 2, data_addr in 32, data_wstrb in 4, data_wdata in 32, data_addr_ok out 1, data_data_ok out 1, data_rdata out 32.
REQ-006 SHALL have AXI3 read-address ports: arid out 4, araddr out 32, arlen out 4, arsize out 3, arburst/arlock out 2, arcache out 4, arprot out 3, arvalid out 1, arready in 1.
REQ-007 SHALL have AXI3 read-data ports: rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
REQ-008 SHALL have AXI3 write ports: awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid out and awready in; wid/wdata/wstrb/wlast/wvalid out and wready in; bid/bresp/bvalid in and bready out. All widths match the read side; wdata is 32 and wstrb is 4.

Function
REQ-009 SHALL drive constant fields: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, awid=wid=4'b0001.
REQ-010 SHALL implement a read FSM with states R_IDLE, R_ADDR and R_DATA, and one outstanding read total.
REQ-011 SHALL, in R_IDLE, accept a data read (data_req&&!data_wr) when the write FSM is W_IDLE; otherwise accept inst_req; data reads always take priority over inst reads.
REQ-012 SHALL pulse the matching *_addr_ok for 1 cycle in the acceptance cycle (combinational), latch the address, size and source, and enter R_ADDR on the next cycle.
REQ-013 SHALL, in R_ADDR, hold arvalid=1 with stable latched fields: arid=1 and arsize={1'b0,size} for data; arid=0 and arsize=3'b010 for inst. On arready it SHALL enter R_DATA.
REQ-014 SHALL, in R_DATA, hold rready=1; on rvalid it SHALL register rdata into the source's *_rdata, pulse that source's *_data_ok in the next cycle, and return to R_IDLE (total latency of at least 3 cycles from addr_ok to data_ok).
REQ-015 SHALL ignore rresp; *_rdata SHALL hold its value until the next read completion.
REQ-016 SHALL implement a write FSM with states W_IDLE, W_SEND and W_RESP.
REQ-017 SHALL, in W_IDLE, accept a data write (data_req&&data_wr) when no data read is accepted in that cycle; it SHALL pulse data_addr_ok, latch addr/size/wstrb/wdata, and set awvalid=wvalid=1 on the next cycle (W_SEND).
REQ-018 SHALL, in W_SEND, drop awvalid and wvalid independently on their own handshakes, entering W_RESP once both have completed, including when both complete in the same cycle.
REQ-019 SHALL, in W_RESP, hold bready=1; on bvalid it SHALL pulse data_data_ok in the same cycle and return to W_IDLE; bresp SHALL be ignored.
REQ-020 SHALL allow a write in flight concurrently with an inst read, but never with a data read (RAW ordering): a data read SHALL stall with data_addr_ok=0 until W_IDLE.
REQ-021 SHALL NOT pulse data_addr_ok twice in one cycle; data_addr_ok SHALL be 0 when R_IDLE and W_IDLE are both false for the requested type.
REQ-022 SHALL keep valid-signal payloads stable while valid=1 and ready=0.

Reset
REQ-023 SHALL, on areset=1 at a clock edge, move both FSMs to IDLE; clear arvalid, awvalid, wvalid, rready, bready, all *_ok and *_rdata to 0; and drop any in-flight transaction without a completion pulse, even if reset arrives mid-handshake.
REQ-024 SHALL generate no addr_ok while areset=1.

Verification
REQ-025 Inst read at 0xBFC00000 with arready=1 immediate and rvalid 2 cycles later, rdata=0x3C1D0000 -> arid=0, araddr=0xBFC00000, inst_data_ok pulses once, inst_rdata=0x3C1D0000.
REQ-026 Inst and data read requested in the same cycle (data_addr=0x80001000) -> data accepted first with arid=1; inst_addr_ok follows only after data_data_ok.
REQ-027 Write to 0x80000010 with wdata 0xDEADBEEF and wstrb 4'b0011; wready 3 cycles before awready -> wvalid drops early, awvalid held, one bvalid produces one data_data_ok.
REQ-028 Data read requested during W_RESP of a write -> data_addr_ok stays 0 until the b handshake, then is accepted; an inst read issued during W_SEND proceeds in parallel.
REQ-029 areset asserted while in R_DATA and W_SEND -> next cycle all valids and readys are 0, no *_data_ok pulses, and a fresh inst read then completes normally.
REQ-030 Back-to-back data_size=0 read at 0x80000003 -> arsize=3'b000 and araddr=0x80000003 passed unmodified.
